// File: rtl/net_sync_controller.sv
// Per-frame network scheduler and race-state sequencer for a two-player kart session.
// Snapshots local state into a 44-bit packet each frame and tracks the peer's packets.
module net_sync_controller #(
  parameter int unsigned TIMEOUT_FRAMES   = 60,
  parameter int unsigned COUNTDOWN_FRAMES = 180
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        frame_tick_in,
  input  logic [10:0] player_x_in,
  input  logic [10:0] player_y_in,
  input  logic [8:0]  player_dir_in,
  input  logic        start_in,
  input  logic        finish_in,
  input  logic        reset_req_in,
  output logic        tx_valid_out,
  output logic [43:0] tx_data_out,
  input  logic        tx_ready_in,
  input  logic        rx_valid_in,
  input  logic [43:0] rx_data_in,
  output logic [10:0] opp_x_out,
  output logic [10:0] opp_y_out,
  output logic [8:0]  opp_dir_out,
  output logic        link_up_out,
  output logic [2:0]  game_state_out,
  output logic [7:0]  countdown_out,
  output logic        race_reset_out,
  output logic [7:0]  tx_drop_count_out
);

  localparam int unsigned ToW = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(TIMEOUT_FRAMES);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StReady     = 3'd1,
    StCountdown = 3'd2,
    StRace      = 3'd3,
    StWon       = 3'd4,
    StLost      = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     cd_q, cd_d;
  logic           tx_valid_q, tx_valid_d;
  logic [43:0]    tx_data_q, tx_data_d;
  logic [2:0]     seq_q, seq_d;
  logic           flag_q, flag_d;
  logic [7:0]     drop_q, drop_d;
  logic [10:0]    opp_x_q, opp_y_q;
  logic [8:0]     opp_dir_q;
  logic [2:0]     opp_state_q, opp_seq_q;
  logic           have_rx_q;
  logic [ToW-1:0] timeout_q;
  logic           race_reset_q;

  logic transfer, accept, session_reset, link_up;

  assign transfer      = tx_valid_q && tx_ready_in;
  // The first packet after reset bypasses the duplicate-seq filter.
  assign accept        = rx_valid_in && (rx_data_in != 44'd0) &&
                         (!have_rx_q || (rx_data_in[10:8] != opp_seq_q));
  assign session_reset = reset_req_in || (accept && rx_data_in[3]);
  assign link_up       = have_rx_q && (timeout_q < ToMax);

  always_comb begin
    seq_d      = transfer ? seq_q + 3'd1 : seq_q;
    flag_d     = reset_req_in ? 1'b1 : (transfer ? 1'b0 : flag_q);
    tx_valid_d = frame_tick_in ? 1'b1 : (transfer ? 1'b0 : tx_valid_q);
    tx_data_d  = tx_data_q;
    drop_d     = drop_q;
    if (frame_tick_in) begin
      tx_data_d = {player_x_in, 1'b0, player_y_in, 1'b0, player_dir_in, seq_d, state_q,
                   1'b0, flag_d, 3'b000};
      if (tx_valid_q && !transfer && drop_q != 8'hff) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    if (session_reset) begin
      state_d = StIdle;
      cd_d    = 8'd0;
    end else begin
      unique case (state_q)
        StIdle: if (start_in) state_d = StReady;
        StReady: begin
          if (link_up && (opp_state_q == 3'd1 || opp_state_q == 3'd2)) begin
            state_d = StCountdown;
            cd_d    = 8'(COUNTDOWN_FRAMES);
          end
        end
        StCountdown: begin
          if (!link_up) begin
            state_d = StReady;
            cd_d    = 8'd0;
          end else if (frame_tick_in) begin
            if (cd_q <= 8'd1) begin
              state_d = StRace;
              cd_d    = 8'd0;
            end else begin
              cd_d = cd_q - 8'd1;
            end
          end
        end
        StRace: begin
          if (finish_in) begin
            state_d = StWon;
          end else if (accept && rx_data_in[7:5] == 3'd4) begin
            state_d = StLost;
          end
        end
        StWon, StLost: if (start_in) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      cd_q         <= 8'd0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 44'd0;
      seq_q        <= 3'd0;
      flag_q       <= 1'b0;
      drop_q       <= 8'd0;
      opp_x_q      <= 11'd0;
      opp_y_q      <= 11'd0;
      opp_dir_q    <= 9'd0;
      opp_state_q  <= 3'd0;
      opp_seq_q    <= 3'd0;
      have_rx_q    <= 1'b0;
      timeout_q    <= ToMax;
      race_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cd_q         <= cd_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      seq_q        <= seq_d;
      flag_q       <= flag_d;
      drop_q       <= drop_d;
      race_reset_q <= session_reset;
      if (accept) begin
        opp_seq_q <= rx_data_in[10:8];
        have_rx_q <= 1'b1;
        timeout_q <= '0;
      end else if (frame_tick_in && timeout_q < ToMax) begin
        timeout_q <= timeout_q + 1'b1;
      end
      if (session_reset) begin
        opp_x_q     <= 11'd0;
        opp_y_q     <= 11'd0;
        opp_dir_q   <= 9'd0;
        opp_state_q <= 3'd0;
      end else if (accept) begin
        opp_x_q     <= rx_data_in[43:33];
        opp_y_q     <= rx_data_in[31:21];
        opp_dir_q   <= rx_data_in[19:11];
        opp_state_q <= rx_data_in[7:5];
      end
    end
  end

  assign tx_valid_out      = tx_valid_q;
  assign tx_data_out       = tx_data_q;
  assign opp_x_out         = opp_x_q;
  assign opp_y_out         = opp_y_q;
  assign opp_dir_out       = opp_dir_q;
  assign link_up_out       = link_up;
  assign game_state_out    = state_q;
  assign countdown_out     = cd_q;
  assign race_reset_out    = race_reset_q;
  assign tx_drop_count_out = drop_q;

endmodule

// File: tb/tb_net_sync_controller.sv
// Directed bench for net_sync_controller: a vector table for TX/lobby behaviour plus
// hand sequences for countdown, race outcomes, session reset and link timeout.
module tb_net_sync_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, start, finish, reset_req, tx_ready, rx_valid;
  logic [10:0] px, py;
  logic [8:0]  pdir;
  logic [43:0] rx_data;
  logic        tx_valid, link_up, race_reset;
  logic [43:0] tx_data;
  logic [10:0] opp_x, opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  state;
  logic [7:0]  cd, drops;

  int errors = 0;
  int checks = 0;
  logic [2:0]  rx_seq;
  logic [43:0] dup;

  net_sync_controller dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .frame_tick_in    (frame_tick),
    .player_x_in      (px),
    .player_y_in      (py),
    .player_dir_in    (pdir),
    .start_in         (start),
    .finish_in        (finish),
    .reset_req_in     (reset_req),
    .tx_valid_out     (tx_valid),
    .tx_data_out      (tx_data),
    .tx_ready_in      (tx_ready),
    .rx_valid_in      (rx_valid),
    .rx_data_in       (rx_data),
    .opp_x_out        (opp_x),
    .opp_y_out        (opp_y),
    .opp_dir_out      (opp_dir),
    .link_up_out      (link_up),
    .game_state_out   (state),
    .countdown_out    (cd),
    .race_reset_out   (race_reset),
    .tx_drop_count_out(drops)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tick, st, rdy, rv;
    logic [43:0] rd;
    logic [10:0] x;
    logic        e_valid;
    logic [43:0] e_data;
    logic [7:0]  e_drop;
    logic        e_link;
    logic [2:0]  e_st;
    logic [7:0]  e_cd;
    logic        e_rr;
    logic [10:0] e_ox;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [43:0] pkt(input logic [10:0] x, input logic [10:0] y,
                                      input logic [8:0] d, input logic [2:0] s,
                                      input logic [2:0] g, input logic f);
    return {x, 1'b0, y, 1'b0, d, s, g, 1'b0, f, 3'b000};
  endfunction

  function automatic vec_t mkv(input logic tick, st, rdy, rv, input logic [43:0] rd,
                               input logic [10:0] x, input logic e_valid,
                               input logic [43:0] e_data, input logic [7:0] e_drop,
                               input logic e_link, input logic [2:0] e_st,
                               input logic [7:0] e_cd, input logic e_rr,
                               input logic [10:0] e_ox);
    vec_t v;
    v = '{tick, st, rdy, rv, rd, x, e_valid, e_data, e_drop, e_link, e_st, e_cd, e_rr, e_ox};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, pass the edge, settle, then drop all pulse inputs.
  task automatic cyc(input logic tk, st, fin, rr, rdy, rv, input logic [43:0] rd);
    frame_tick = tk; start = st; finish = fin; reset_req = rr;
    tx_ready = rdy; rx_valid = rv; rx_data = rd;
    @(posedge clk);
    #1;
    frame_tick = 0; start = 0; finish = 0; reset_req = 0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
  endtask

  task automatic countdown_run();
    for (int i = 0; i < 180; i++) begin
      cyc(1, 0, 0, 0, 1, 1, pkt(11'd100, 11'd50, 9'd90, rx_seq, 3'd2, 1'b0));
      rx_seq = rx_seq + 3'd1;
      if (i == 178) begin
        chk("cd_penultimate_state", state, 2);
        chk("cd_penultimate_value", cd, 1);
      end
      if (i == 179) begin
        chk("cd_done_state", state, 3);
        chk("cd_done_value", cd, 0);
        chk("cd_done_link", link_up, 1);
      end
    end
  endtask

  task automatic enter_race();
    cyc(0, 1, 0, 0, 0, 0, '0);
    chk("lobby_ready", state, 1);
    cyc(0, 0, 0, 0, 0, 1, pkt(11'd100, 11'd50, 9'd90, rx_seq, 3'd1, 1'b0));
    rx_seq = rx_seq + 3'd1;
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("lobby_countdown", state, 2);
    chk("lobby_cd_load", cd, 180);
    countdown_run();
  endtask

  initial begin
    rst = 1; px = 11'd191; py = 11'd191; pdir = 9'd270;
    frame_tick = 0; start = 0; finish = 0; reset_req = 0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    rx_seq = 3'd6;

    vecs[0] = mkv(0, 0, 0, 0, '0, 11'd191, 0, '0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mkv(1, 0, 1, 0, '0, 11'd191, 1,
                  pkt(11'd191, 11'd191, 9'd270, 3'd0, 3'd0, 1'b0), 0, 0, 0, 0, 0, 0);
    vecs[2] = mkv(0, 0, 1, 0, '0, 11'd191, 0,
                  pkt(11'd191, 11'd191, 9'd270, 3'd0, 3'd0, 1'b0), 0, 0, 0, 0, 0, 0);
    vecs[3] = mkv(1, 0, 0, 0, '0, 11'd10, 1,
                  pkt(11'd10, 11'd191, 9'd270, 3'd1, 3'd0, 1'b0), 0, 0, 0, 0, 0, 0);
    vecs[4] = mkv(1, 0, 0, 0, '0, 11'd20, 1,
                  pkt(11'd20, 11'd191, 9'd270, 3'd1, 3'd0, 1'b0), 1, 0, 0, 0, 0, 0);
    vecs[5] = mkv(1, 0, 0, 0, '0, 11'd30, 1,
                  pkt(11'd30, 11'd191, 9'd270, 3'd1, 3'd0, 1'b0), 2, 0, 0, 0, 0, 0);
    vecs[6] = mkv(0, 0, 1, 0, '0, 11'd30, 0,
                  pkt(11'd30, 11'd191, 9'd270, 3'd1, 3'd0, 1'b0), 2, 0, 0, 0, 0, 0);
    vecs[7] = mkv(0, 1, 0, 0, '0, 11'd30, 0,
                  pkt(11'd30, 11'd191, 9'd270, 3'd1, 3'd0, 1'b0), 2, 0, 1, 0, 0, 0);
    vecs[8] = mkv(0, 0, 0, 1, pkt(11'd100, 11'd50, 9'd90, 3'd5, 3'd1, 1'b0), 11'd30, 0,
                  pkt(11'd30, 11'd191, 9'd270, 3'd1, 3'd0, 1'b0), 2, 1, 1, 0, 0, 11'd100);
    vecs[9] = mkv(0, 0, 0, 0, '0, 11'd30, 0,
                  pkt(11'd30, 11'd191, 9'd270, 3'd1, 3'd0, 1'b0), 2, 1, 2, 180, 0, 11'd100);

    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < 10; i++) begin
      px = vecs[i].x;
      cyc(vecs[i].tick, vecs[i].st, 0, 0, vecs[i].rdy, vecs[i].rv, vecs[i].rd);
      chk($sformatf("v%0d_valid", i), tx_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_data", i), tx_data, vecs[i].e_data);
      chk($sformatf("v%0d_drops", i), drops, vecs[i].e_drop);
      chk($sformatf("v%0d_link", i), link_up, vecs[i].e_link);
      chk($sformatf("v%0d_state", i), state, vecs[i].e_st);
      chk($sformatf("v%0d_cd", i), cd, vecs[i].e_cd);
      chk($sformatf("v%0d_rr", i), race_reset, vecs[i].e_rr);
      chk($sformatf("v%0d_oppx", i), opp_x, vecs[i].e_ox);
    end
    chk("opp_y", opp_y, 50);
    chk("opp_dir", opp_dir, 90);

    countdown_run();

    // Finish and a peer WON packet together: local finish wins.
    cyc(0, 0, 1, 0, 0, 1, pkt(11'd100, 11'd50, 9'd90, rx_seq, 3'd4, 1'b0));
    rx_seq = rx_seq + 3'd1;
    chk("race_finish_priority", state, 4);
    cyc(0, 1, 0, 0, 0, 0, '0);
    chk("won_to_idle", state, 0);

    enter_race();
    cyc(0, 0, 0, 0, 0, 1, pkt(11'd100, 11'd50, 9'd90, rx_seq, 3'd4, 1'b0));
    rx_seq = rx_seq + 3'd1;
    chk("race_peer_won_lost", state, 5);
    cyc(0, 1, 0, 0, 0, 0, '0);
    chk("lost_to_idle", state, 0);

    enter_race();
    cyc(0, 0, 0, 0, 0, 1, pkt(11'd100, 11'd50, 9'd90, rx_seq, 3'd3, 1'b1));
    rx_seq = rx_seq + 3'd1;
    chk("remote_reset_state", state, 0);
    chk("remote_reset_pulse", race_reset, 1);
    chk("remote_reset_oppx", opp_x, 0);
    chk("remote_reset_oppy", opp_y, 0);
    chk("remote_reset_oppdir", opp_dir, 0);
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("remote_reset_pulse_end", race_reset, 0);
    cyc(1, 0, 0, 0, 0, 0, '0);
    chk("remote_reset_no_flag", tx_data[3], 0);
    chk("remote_reset_tx_game", tx_data[7:5], 0);

    cyc(0, 0, 0, 1, 0, 0, '0);
    chk("local_reset_pulse", race_reset, 1);
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("local_reset_pulse_end", race_reset, 0);
    cyc(1, 0, 0, 0, 0, 0, '0);
    chk("local_reset_flag_set", tx_data[3], 1);
    cyc(0, 0, 0, 0, 1, 0, '0);
    chk("flag_transfer_valid", tx_valid, 0);
    cyc(1, 0, 0, 0, 0, 0, '0);
    chk("flag_cleared_after_tx", tx_data[3], 0);
    chk("flag_next_valid", tx_valid, 1);

    // Link timeout during countdown.
    cyc(0, 1, 0, 0, 0, 0, '0);
    dup = pkt(11'd100, 11'd50, 9'd90, rx_seq, 3'd1, 1'b0);
    cyc(0, 0, 0, 0, 0, 1, dup);
    rx_seq = rx_seq + 3'd1;
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("to_countdown", state, 2);
    for (int i = 0; i < 60; i++) begin
      cyc(1, 0, 0, 0, 1, 0, '0);
      if (i == 58) chk("to_link_still_up", link_up, 1);
      if (i == 59) chk("to_link_down", link_up, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, '0);
    chk("to_back_ready", state, 1);
    chk("to_cd_cleared", cd, 0);
    dup[43:33] = 11'd555;
    cyc(0, 0, 0, 0, 0, 1, dup);
    chk("dup_seq_link", link_up, 0);
    chk("dup_seq_oppx", opp_x, 100);
    cyc(0, 0, 0, 0, 0, 1, '0);
    chk("zero_pkt_link", link_up, 0);
    chk("zero_pkt_state", state, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/net_sync_controller.md
# net_sync_controller

Per-frame network scheduler and race-state sequencer for two-player kart sessions. Once per video frame it snapshots local player state into a 44-bit packet and hands it to the Ethernet transmitter over a valid/ready handshake. It also validates packets from the receiver, keeps the opponent's position and heading, and tracks link liveness. A game FSM, shared with the peer through the packet's game field, sequences IDLE → READY → COUNTDOWN → RACE → WON/LOST.

## Interface
- TIMEOUT_FRAMES, 60: frames with no valid rx packet before link is declared down
- COUNTDOWN_FRAMES, 180: frames spent in COUNTDOWN
- clk_in  input  1  system clock (eth_refclk domain)
- rst_in  input  1  synchronous, active-high reset
- frame_tick_in  input  1  one-cycle pulse per video frame
- player_x_in / player_y_in  input  11 each  local kart position
- player_dir_in  input  9  local heading, 0–359
- start_in  input  1  pulse: local player ready / return to lobby
- finish_in  input  1  pulse: local kart crossed the finish line
- reset_req_in  input  1  pulse: request a session reset on both boards
- tx_valid_out  output  1  packet pending for transmitter
- tx_data_out  output  44  packet
- tx_ready_in  input  1  transmitter idle; transfer when valid && ready
- rx_valid_in  input  1  one-cycle pulse, rx_data_in valid
- rx_data_in  input  44  received packet
- opp_x_out / opp_y_out  output  11 each; opp_dir_out  output  9  latched opponent state
- link_up_out  output  1  peer heard within TIMEOUT_FRAMES
- game_state_out  output  3  0 IDLE, 1 READY, 2 COUNTDOWN, 3 RACE, 4 WON, 5 LOST
- countdown_out  output  8  remaining countdown frames
- race_reset_out  output  1  one-cycle pulse on session reset
- tx_drop_count_out  output  8  saturating count of overwritten snapshots

## Operation
- Packet fields: [43:33] x, [31:21] y, [19:11] dir, [10:8] seq, [7:5] game state, [3] reset flag. All other bits are 0.
- TX: on frame_tick_in, load tx_data_out from the current inputs, state, seq and reset flag, then set tx_valid_out.
  - tx_valid_out and tx_data_out stay stable until a transfer.
  - On transfer: seq increments mod 8, reset flag clears, and tx_valid_out drops unless a frame_tick arrives in the same cycle.
  - frame_tick while a packet is pending and not transferring: overwrite with the new snapshot, seq unchanged, tx_drop_count_out +1 (saturates at 255).
- Reset flag: set by reset_req_in and carried in the next transferred packet.
- RX accept: rx_valid_in && rx_data_in != 0 && seq differs from the last accepted seq. The first packet after reset is always accepted.
  - On accept: latch opp x/y/dir, store the opponent's game state and seq, clear the timeout counter.
- Timeout counter: increments on each frame_tick and saturates at TIMEOUT_FRAMES. link_up_out = (count < TIMEOUT_FRAMES) and at least one packet has been accepted since reset.
- Game FSM:
  - IDLE: start_in → READY.
  - READY: link_up_out && opponent state ∈ {READY, COUNTDOWN} → COUNTDOWN, countdown loaded with COUNTDOWN_FRAMES.
  - COUNTDOWN: decrement on frame_tick; when the decremented value reaches 0 → RACE. Link down → READY, countdown cleared.
  - RACE: finish_in → WON. Accepted packet with opponent state WON and no finish_in that cycle → LOST. finish_in has priority when both occur in the same cycle. Link loss does not leave RACE.
  - WON/LOST: start_in → IDLE.
- Session reset: reset_req_in, or an accepted packet with reset flag = 1, from any state → IDLE. It pulses race_reset_out, clears countdown and opponent state, and has priority over all other transitions. Local reset_req_in also sets the reset flag; a remote reset does not.

## Timing
- rst_in: tx_valid_out=0, tx_data_out=0, seq=0, opp_*=0, link_up_out=0, game_state_out=0, countdown_out=0, race_reset_out=0, tx_drop_count_out=0, timeout counter = TIMEOUT_FRAMES.
- tx_valid_out rises 1 cycle after frame_tick_in.
- opp_* and link_up_out update 1 cycle after an accepted rx_valid_in.
- State transitions register 1 cycle after the triggering input.
- race_reset_out is high exactly 1 cycle, 1 cycle after the trigger.
- Simultaneous rx accept and frame_tick: the counter clears; the accept wins.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset, then frame_tick with tx_ready_in=1, x=191, y=191, dir=270 → one cycle later tx_valid_out=1 and tx_data_out = {191,0,191,0,270,3'd0,3'd0,0,0,3'b0}; seq becomes 1 after transfer.
- Hold tx_ready_in=0 across 3 frame_ticks → tx_data_out shows the last snapshot, tx_drop_count_out=2, seq unchanged.
- start_in, then accept a peer packet with game=1 → state READY → COUNTDOWN with countdown_out=180. After 180 frame_ticks, state=RACE.
- In RACE, finish_in and a peer WON packet in the same cycle → WON. Separately, a peer WON packet alone → LOST.
- In COUNTDOWN, stop rx for 60 frame_ticks → link_up_out=0 and state=READY. A duplicate-seq or all-zero packet does not restore the link.
- Accepted peer packet with bit 3=1 while in RACE → IDLE, one-cycle race_reset_out, opp_*=0, and no reset flag in the next tx packet.
